// File: rtl/mul_share_arb_if.sv
// ---------------------------------------------------------------------------
// mul_share_arb_if
// Requester-side bundle of the shared-multiplier arbiter.
//
// Signals (requester i owns slice i of each packed vector):
//   req_valid [NREQ]        operand pair valid, one bit per requester
//   req_a     [NREQ*ASIZE]  operand A of requester i at [i*ASIZE +: ASIZE]
//   req_b     [NREQ*BSIZE]  operand B of requester i at [i*BSIZE +: BSIZE]
//   req_ready [NREQ]        one-hot grant, combinational
//   res_valid [NREQ]        one-hot result valid, registered
//   res_p     [PSIZE]       product, shared by all requesters
//   res_id    [IDW]         index of the result owner
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mul_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int ASIZE = 17,
    parameter int BSIZE = 17,
    parameter int PSIZE = 34,
    parameter int IDW   = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ASIZE-1:0] req_a;
    logic [NREQ*BSIZE-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       res_valid;
    logic [PSIZE-1:0]      res_p;
    logic [IDW-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_p, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_p, res_id
    );
endinterface

// File: rtl/mul_share_arb.sv
// ---------------------------------------------------------------------------
// mul_share_arb
// Shares one pipelined signed multiplier (PIPE_LAT result registers, no
// input/output register) among NREQ requesters. A round-robin arbiter picks
// at most one operand pair per cycle, a tag pipeline follows the operands
// through the multiplier, and each product is returned to its owner with a
// one-hot valid PIPE_LAT+2 cycles after the handshake.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   en       1 = new grants allowed, 0 = drain only
//   bus      requester bundle (slave side): req_valid/req_a/req_b/req_ready,
//            res_valid/res_p/res_id
//   mul_rst  multiplier reset (active high), registered copy of ~rst_n
//   mul_a    operand A to the multiplier, registered
//   mul_b    operand B to the multiplier, registered
//   mul_p    product from the multiplier
//   busy     registered OR of all tag-stage valid bits
// ---------------------------------------------------------------------------
module mul_share_arb #(
    parameter int NREQ     = 4,
    parameter int ASIZE    = 17,
    parameter int BSIZE    = 17,
    parameter int PSIZE    = 34,
    parameter int PIPE_LAT = 3,
    parameter int IDW      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    mul_share_arb_if.slave    bus,
    output logic              mul_rst,
    output logic [ASIZE-1:0]  mul_a,
    output logic [BSIZE-1:0]  mul_b,
    input  logic [PSIZE-1:0]  mul_p,
    output logic              busy
);

    // Round-robin pointer: index of the most recently granted requester.
    logic [IDW-1:0]   ptr;

    logic             found_hi;
    logic             found_lo;
    logic [IDW-1:0]   hi_id;
    logic [IDW-1:0]   lo_id;
    logic [IDW-1:0]   grant_id;
    logic             xfer;
    logic [NREQ-1:0]  grant;
    logic [ASIZE-1:0] grant_a;
    logic [BSIZE-1:0] grant_b;

    // Tag pipeline: stage k travels alongside the multiplier's k-th register.
    logic [PIPE_LAT:0] tag_valid;
    logic [IDW-1:0]    tag_id [PIPE_LAT+1];

    logic [NREQ-1:0]  res_onehot;
    logic [NREQ-1:0]  res_valid_q;
    logic [PSIZE-1:0] res_p_q;
    logic [IDW-1:0]   res_id_q;

    // Round-robin search split in two passes: first the requesters above
    // ptr, then (wrapping) from index 0 upward. The first hit of the upper
    // pass wins; otherwise the lowest valid requester overall wins, which is
    // exactly the wrapped continuation of the search.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && !found_hi && (IDW'(i) > ptr)) begin
                found_hi = 1'b1;
                hi_id    = IDW'(i);
            end
            if (bus.req_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                lo_id    = IDW'(i);
            end
        end
        grant_id = found_hi ? hi_id : lo_id;
        xfer     = en && (found_hi || found_lo);
    end

    // One-hot grant plus operand mux; operands of a non-granted cycle are 0
    // so the multiplier sees a clean zero when idle.
    always_comb begin
        grant   = '0;
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && (grant_id == IDW'(i))) begin
                grant[i] = 1'b1;
                grant_a  = bus.req_a[i*ASIZE +: ASIZE];
                grant_b  = bus.req_b[i*BSIZE +: BSIZE];
            end
        end
    end

    // The last tag stage lines up with mul_p; decode its owner to one-hot.
    always_comb begin
        res_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag_valid[PIPE_LAT] && (tag_id[PIPE_LAT] == IDW'(i))) begin
                res_onehot[i] = 1'b1;
            end
        end
    end

    // All state in one block. Reset discards every in-flight tag, so no
    // result is reported for operations issued before the reset.
    always_ff @(posedge clk) begin
        mul_rst <= ~rst_n;
        if (!rst_n) begin
            ptr         <= IDW'(NREQ-1);
            mul_a       <= '0;
            mul_b       <= '0;
            tag_valid   <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                tag_id[k] <= '0;
            end
            res_valid_q <= '0;
            res_p_q     <= '0;
            res_id_q    <= '0;
            busy        <= 1'b0;
        end else begin
            if (xfer) begin
                ptr <= grant_id;
            end
            mul_a     <= grant_a;
            mul_b     <= grant_b;
            tag_valid <= {tag_valid[PIPE_LAT-1:0], xfer};
            tag_id[0] <= grant_id;
            for (int k = 1; k <= PIPE_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
            busy        <= |tag_valid;
            res_valid_q <= res_onehot;
            if (tag_valid[PIPE_LAT]) begin
                res_p_q  <= mul_p;
                res_id_q <= tag_id[PIPE_LAT];
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_p     = res_p_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arb
// Self-checking bench for mul_share_arb. A behavioural multiplier closes the
// loop on mul_a/mul_b -> mul_p. A reference arbiter (spec rules, plain int
// arithmetic) predicts every grant and pushes the expected result into a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT raises res_valid.
// ---------------------------------------------------------------------------
module tb_mul_share_arb;

    localparam int NREQ     = 4;
    localparam int ASIZE    = 17;
    localparam int BSIZE    = 17;
    localparam int PSIZE    = 34;
    localparam int PIPE_LAT = 3;
    localparam int IDW      = 3;
    localparam int SOAK_CYC = 10000;

    typedef struct {
        int               id;
        logic [PSIZE-1:0] p;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mul_rst;
    logic [ASIZE-1:0] mul_a;
    logic [BSIZE-1:0] mul_b;
    logic [PSIZE-1:0] mul_p;
    logic             busy;

    mul_share_arb_if #(
        .NREQ(NREQ), .ASIZE(ASIZE), .BSIZE(BSIZE), .PSIZE(PSIZE), .IDW(IDW)
    ) bus ();

    mul_share_arb #(
        .NREQ(NREQ), .ASIZE(ASIZE), .BSIZE(BSIZE), .PSIZE(PSIZE),
        .PIPE_LAT(PIPE_LAT), .IDW(IDW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .bus(bus),
        .mul_rst(mul_rst),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_p(mul_p),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural pipelined multiplier: PIPE_LAT result registers.
    logic [PSIZE-1:0] mpipe [PIPE_LAT];
    always @(posedge clk) begin
        if (mul_rst) begin
            for (int k = 0; k < PIPE_LAT; k++) mpipe[k] <= '0;
        end else begin
            mpipe[0] <= PSIZE'($signed(mul_a)) * PSIZE'($signed(mul_b));
            for (int k = 1; k < PIPE_LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_p = mpipe[PIPE_LAT-1];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int fails  = 0;

    exp_t sb [$];
    int   hs_q [$];

    logic [ASIZE-1:0] aval [NREQ];
    logic [BSIZE-1:0] bval [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [PSIZE-1:0] ref_prod(input logic [ASIZE-1:0] a, input logic [BSIZE-1:0] b);
        longint sa;
        longint sb2;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        return PSIZE'(sa * sb2);
    endfunction

    function automatic logic [ASIZE-1:0] rand_a();
        case ($urandom_range(0, 7))
            0:       return ASIZE'(17'h10000);
            1:       return ASIZE'(17'h1FFFF);
            2:       return ASIZE'(17'h0FFFF);
            3:       return '0;
            4:       return ASIZE'(1);
            default: return ASIZE'($urandom);
        endcase
    endfunction

    function automatic logic [BSIZE-1:0] rand_b();
        case ($urandom_range(0, 7))
            0:       return BSIZE'(17'h10000);
            1:       return BSIZE'(17'h1FFFF);
            2:       return BSIZE'(17'h0FFFF);
            3:       return '0;
            4:       return BSIZE'(1);
            default: return BSIZE'($urandom);
        endcase
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            aval[i] = rand_a();
            bval[i] = rand_b();
        end
    endtask

    // Drive one cycle of inputs, then move to 1 ns after the next edge.
    task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic e, input logic r);
        logic [NREQ*ASIZE-1:0] pa;
        logic [NREQ*BSIZE-1:0] pb;
        for (int i = 0; i < NREQ; i++) begin
            pa[i*ASIZE +: ASIZE] = aval[i];
            pb[i*BSIZE +: BSIZE] = bval[i];
        end
        bus.req_a     = pa;
        bus.req_b     = pb;
        bus.req_valid = v;
        en            = e;
        rst_n         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus('0, 1'b1, 1'b1);
    endtask

    // Reference arbiter: predicts grants, busy and the multiplier operands,
    // and pushes every predicted result into the scoreboard.
    int               m_ptr = NREQ-1;
    logic             prev_rst_n = 1'b0;
    logic [ASIZE-1:0] exp_mul_a = '0;
    logic [BSIZE-1:0] exp_mul_b = '0;
    int               g;
    logic [NREQ-1:0]  exp_ready;
    logic             exp_busy;

    always @(negedge clk) begin
        g = -1;
        if (en === 1'b1) begin
            for (int off = 1; off <= NREQ; off++) begin
                if (g < 0 && bus.req_valid[(m_ptr + off) % NREQ] === 1'b1) g = (m_ptr + off) % NREQ;
            end
        end
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;

        while (hs_q.size() > 0 && hs_q[0] < cycle - 2 - PIPE_LAT) void'(hs_q.pop_front());
        exp_busy = 1'b0;
        foreach (hs_q[k]) if (hs_q[k] <= cycle - 2) exp_busy = 1'b1;

        if (cycle >= 1) begin
            check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(exp_busy));
            check("mul_rst", 64'(mul_rst), 64'(!prev_rst_n));
            check("mul_a", 64'(mul_a), 64'(exp_mul_a));
            check("mul_b", 64'(mul_b), 64'(exp_mul_b));
        end

        if (rst_n !== 1'b1) begin
            m_ptr = NREQ-1;
            hs_q.delete();
            exp_mul_a = '0;
            exp_mul_b = '0;
        end else if (g >= 0) begin
            m_ptr = g;
            sb.push_back('{g, ref_prod(aval[g], bval[g]), cycle + PIPE_LAT + 2});
            hs_q.push_back(cycle);
            exp_mul_a = aval[g];
            exp_mul_b = bval[g];
        end else begin
            exp_mul_a = '0;
            exp_mul_b = '0;
        end
        prev_rst_n = rst_n;
    end

    // Result monitor: decoupled from the stimulus side, consumes the queue.
    exp_t             e;
    logic [PSIZE-1:0] last_p  = '0;
    logic [IDW-1:0]   last_id = '0;

    always @(negedge clk) begin
        if (cycle >= 1) begin
            if (bus.res_valid !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(bus.res_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("res_latency", 64'(cycle), 64'(e.cyc));
                    check("res_valid", 64'(bus.res_valid), 64'(NREQ'(1) << e.id));
                    check("res_id", 64'(bus.res_id), 64'(e.id));
                    check("res_p", 64'(bus.res_p), 64'(e.p));
                    last_p  = e.p;
                    last_id = IDW'(e.id);
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cycle) begin
                    e = sb.pop_front();
                    check("missing_result", 64'(bus.res_valid), 64'(NREQ'(1) << e.id));
                end
                check("res_p_hold", 64'(bus.res_p), 64'(last_p));
                check("res_id_hold", 64'(bus.res_id), 64'(last_id));
            end
        end
        if (rst_n !== 1'b1) begin
            sb.delete();
            last_p  = '0;
            last_id = '0;
        end
    end

    // Directed signed vectors for requester 1.
    logic [ASIZE-1:0] dir_a [4];
    logic [BSIZE-1:0] dir_b [4];

    initial begin
        dir_a[0] = 17'h1FFFF; dir_b[0] = 17'h1FFFF;
        dir_a[1] = 17'h10000; dir_b[1] = 17'h10000;
        dir_a[2] = 17'h0FFFF; dir_b[2] = 17'h0FFFF;
        dir_a[3] = 17'h0FFFF; dir_b[3] = 17'h1FFFF;

        // Reset with every requester valid; ready stays combinational.
        for (int k = 0; k < 3; k++) begin
            randomize_ops();
            apply_stimulus('1, 1'b1, 1'b0);
        end
        randomize_ops();
        apply_stimulus('1, 1'b1, 1'b1);
        idle(6);

        // Signed corner products, one requester at a time.
        for (int k = 0; k < 4; k++) begin
            randomize_ops();
            aval[1] = dir_a[k];
            bval[1] = dir_b[k];
            apply_stimulus(4'b0010, 1'b1, 1'b1);
            idle(1);
        end
        idle(6);

        // Full contention: strict rotation and back-to-back results.
        for (int k = 0; k < 12; k++) begin
            randomize_ops();
            apply_stimulus('1, 1'b1, 1'b1);
        end
        idle(8);

        // Sparse requests and pointer wrap: park ptr at 2, then 3, then 1.
        randomize_ops();
        apply_stimulus(4'b0100, 1'b1, 1'b1);
        apply_stimulus(4'b1010, 1'b1, 1'b1);
        apply_stimulus(4'b0010, 1'b1, 1'b1);
        idle(8);

        // Drain: three ops in flight, then en low with everyone requesting.
        for (int k = 0; k < 3; k++) begin
            randomize_ops();
            apply_stimulus('1, 1'b1, 1'b1);
        end
        for (int k = 0; k < 10; k++) apply_stimulus('1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            randomize_ops();
            apply_stimulus('1, 1'b1, 1'b1);
        end
        idle(8);

        // Reset with four operations in flight.
        for (int k = 0; k < 4; k++) begin
            randomize_ops();
            apply_stimulus('1, 1'b1, 1'b1);
        end
        apply_stimulus('1, 1'b1, 1'b0);
        idle(8);

        // Random soak with occasional drain and reset.
        for (int k = 0; k < SOAK_CYC; k++) begin
            randomize_ops();
            apply_stimulus(NREQ'($urandom), ($urandom_range(0, 6) != 0),
                           ($urandom_range(0, 499) != 0));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined 17x17 signed multiplier (PIPE_LAT result registers, no input or output register, ce tied high) among NREQ requesters.
- Requesters are typically the audio filter and voice-effect channels.
- Arbitrates round-robin, issues at most one operand pair per cycle, and tracks requester identity through the multiplier pipeline.
- Returns each product to its originating requester with a one-hot valid.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ASIZE, 17, operand A width, signed.
- BSIZE, 17, operand B width, signed.
- PSIZE, 34, product width; must equal ASIZE+BSIZE.
- PIPE_LAT, 3, multiplier latency in clk edges from operand to product.
- IDW, 3, requester index width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  1 = new grants allowed; 0 = drain, no new grants.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*ASIZE  requester i operand A at bits [i*ASIZE +: ASIZE].
- req_b  in  NREQ*BSIZE  requester i operand B at bits [i*BSIZE +: BSIZE].
- req_ready  out  NREQ  one-hot grant, combinational.
- mul_rst  out  1  multiplier reset, active-high; equals ~rst_n, registered.
- mul_a  out  ASIZE  operand A to multiplier, registered.
- mul_b  out  BSIZE  operand B to multiplier, registered.
- mul_p  in  PSIZE  product from multiplier.
- res_valid  out  NREQ  one-hot result valid, registered.
- res_p  out  PSIZE  product, registered, shared by all requesters.
- res_id  out  IDW  index of the result owner, registered.
- busy  out  1  1 while any operation is in flight.

Behaviour:

Reset:
- rst_n=0 sampled at an edge forces: mul_a=0, mul_b=0, res_valid=0, res_p=0, res_id=0, busy=0, all tag stages invalid, mul_rst=1.
- Round-robin pointer is set to NREQ-1, so requester 0 has first priority.
- Reset mid-operation discards all in-flight tags; no res_valid is raised for them after reset.

Arbitration:
- req_ready[i] = en & req_valid[i] & (i is the first requester with valid set, searching from ptr+1 upward with wrap modulo NREQ).
- req_ready depends combinationally on req_valid and is never asserted for a non-valid requester.
- Transfer occurs when req_valid[i] & req_ready[i] in cycle c.
- On transfer, ptr <= i. With no transfer, ptr holds.
- A requester may hold req_valid high across cycles. Under contention it is served at least once every NREQ cycles.

Issue:
- Transfer in cycle c: mul_a/mul_b carry requester i's operands in cycle c+1.
- With no transfer, mul_a/mul_b are driven to 0 in the following cycle.
- Operands pass through unmodified as two's complement; the arbiter does no arithmetic.

Tag pipeline:
- Depth PIPE_LAT+1. Each stage holds {valid, id}.
- Stage 0 is loaded alongside mul_a/mul_b. Each stage advances every cycle; there are no stalls.
- mul_p corresponding to stage-0 entry k is valid in cycle c+1+PIPE_LAT.

Result:
- In cycle c+2+PIPE_LAT: res_valid[id]=1 (one-hot), res_id=id, res_p=mul_p as captured.
- Total latency is PIPE_LAT+2 cycles from the handshake; 5 cycles at default.
- When the last stage is invalid, res_valid=0 and res_p/res_id hold their previous values.
- Results cannot be back-pressured; requesters must accept every res_valid.

Throughput and control:
- One transfer per cycle; back-to-back transfers yield back-to-back results in the same order.
- busy = OR of all tag-stage valid bits, registered.
- en=0 blocks new transfers only. In-flight operations complete and busy falls once the pipe is empty.
- en may toggle in any cycle; ptr does not move while en=0.

Test Plan:
- Reset and defaults: rst_n=0 for 3 cycles with all req_valid=1 -> req_ready remains asserted combinationally (only res_valid/busy/mul_* are reset-forced); res_valid=0, busy=0, mul_rst=1. After release, first grant goes to requester 0.
- Signed arithmetic via a MUL model with PIPE_LAT=3, one requester each:
  - req1 a=17'h1FFFF, b=17'h1FFFF -> res_p=34'h1 after 5 cycles, res_valid=4'b0010, res_id=1.
  - a=17'h10000, b=17'h10000 -> res_p=34'h1_0000_0000.
  - a=17'h0FFFF, b=17'h0FFFF -> res_p=34'h0_FFFE_0001.
  - a=17'h0FFFF, b=17'h1FFFF -> res_p=34'h3_FFFF_0001.
- Round-robin fairness: all 4 req_valid held high for 12 cycles -> grant order 0,1,2,3,0,1,2,3,... Results return in the same order, one per cycle starting 5 cycles after the first grant.
- Sparse and wrap: ptr=2, only req_valid[1] and [3] high -> grant 3 then 1. Drop [3] after its grant -> 1 granted; ptr wraps correctly.
- Drain: en=0 asserted with 3 ops in flight -> no req_ready; the 3 results still appear; busy falls 1 cycle after the last res_valid; ptr unchanged.
- Reset mid-flight: 4 ops in flight, rst_n=0 for 1 cycle -> no res_valid afterwards for those ops; busy=0 next cycle.
- Random soak: 100000 ns of random valid/operands vs a reference model, checking product, id, and order on every res_valid.
